// File: rtl/nn_weight_loader_pkg.sv
// Shared widths, default sizes and state encoding for the network parameter loader.
package nn_weight_loader_pkg;

    localparam int unsigned WRITE_IN_BIT_WIDTH = 16;
    localparam int unsigned RELU_NODES         = 32;
    localparam int unsigned INPUT_PIXELS       = 784;
    localparam int unsigned ADDR_W             = 10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        L1_WEIGHTS = 3'd1,
        L1_BIAS    = 3'd2,
        L2_WEIGHTS = 3'd3,
        L2_BIAS    = 3'd4,
        DONE       = 3'd5
    } load_state_e;

    // True in the states where a host beat can be accepted.
    function automatic logic is_load_state(input load_state_e s);
        return (s == L1_WEIGHTS) || (s == L1_BIAS) || (s == L2_WEIGHTS) || (s == L2_BIAS);
    endfunction

endpackage

// File: rtl/nn_weight_loader_if.sv
// Host handshake and network write-port bundle of the parameter loader.
interface nn_weight_loader_if
    import nn_weight_loader_pkg::*;
#(
    parameter int unsigned DATA_W = WRITE_IN_BIT_WIDTH
);
    logic              start;
    logic              dataValid;
    logic [DATA_W-1:0] dataIn;
    logic              dataReady;
    logic              weightWriteEnable;
    logic              biasWriteEnable;
    logic              LayerWriteSelect;
    logic [ADDR_W-1:0] WriteAddressSelect;
    logic [DATA_W-1:0] writeIn;
    logic              busy;
    logic              loadDone;

    modport master (
        output start, dataValid, dataIn,
        input  dataReady, weightWriteEnable, biasWriteEnable, LayerWriteSelect,
        input  WriteAddressSelect, writeIn, busy, loadDone
    );

    modport slave (
        input  start, dataValid, dataIn,
        output dataReady, weightWriteEnable, biasWriteEnable, LayerWriteSelect,
        output WriteAddressSelect, writeIn, busy, loadDone
    );
endinterface

// File: rtl/nn_weight_loader.sv
// Streams host words into layer-1/layer-2 weights and biases of the network.
module nn_weight_loader
    import nn_weight_loader_pkg::*;
#(
    parameter int unsigned DATA_W          = WRITE_IN_BIT_WIDTH,
    parameter int unsigned L1_WEIGHT_COUNT = INPUT_PIXELS,
    parameter int unsigned L2_WEIGHT_COUNT = RELU_NODES
) (
    input logic               clk,
    input logic               reset,
    nn_weight_loader_if.slave bus
);

    localparam logic [ADDR_W-1:0] L1_LAST = ADDR_W'(L1_WEIGHT_COUNT - 1);
    localparam logic [ADDR_W-1:0] L2_LAST = ADDR_W'(L2_WEIGHT_COUNT - 1);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d;
    logic              wen_q, wen_d;
    logic              ben_q, ben_d;
    logic              layer_q, layer_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept_c;

    assign accept_c = bus.dataValid && ready_q;

    // State register and registered write-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ready_q <= 1'b0;
            wen_q   <= 1'b0;
            ben_q   <= 1'b0;
            layer_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            wen_q   <= wen_d;
            ben_q   <= ben_d;
            layer_q <= layer_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, address sequencing and write strobe generation.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = 1'b0;
        ben_d   = 1'b0;
        layer_d = layer_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        busy_d  = 1'b0;

        // Every accepted beat latches its address/data; strobes are set per state below.
        if (accept_c) begin
            waddr_d = addr_q;
            wdata_d = DATA_W'(bus.dataIn);
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start && !busy_q) begin
                    state_d = L1_WEIGHTS;
                    addr_d  = '0;
                    done_d  = 1'b0;
                end
            end
            L1_WEIGHTS: begin
                if (accept_c) begin
                    wen_d   = 1'b1;
                    layer_d = 1'b0;
                    if (addr_q == L1_LAST) begin
                        state_d = L1_BIAS;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            L1_BIAS: begin
                if (accept_c) begin
                    ben_d   = 1'b1;
                    layer_d = 1'b0;
                    state_d = L2_WEIGHTS;
                end
            end
            L2_WEIGHTS: begin
                if (accept_c) begin
                    wen_d   = 1'b1;
                    layer_d = 1'b1;
                    if (addr_q == L2_LAST) begin
                        state_d = L2_BIAS;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            L2_BIAS: begin
                if (accept_c) begin
                    ben_d   = 1'b1;
                    layer_d = 1'b1;
                    state_d = DONE;
                    done_d  = 1'b1;
                    // Busy stays up through the final strobe cycle.
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase

        ready_d = is_load_state(state_d);
        if (is_load_state(state_d)) begin
            busy_d = 1'b1;
        end
    end

    assign bus.dataReady          = ready_q;
    assign bus.weightWriteEnable  = wen_q;
    assign bus.biasWriteEnable    = ben_q;
    assign bus.LayerWriteSelect   = layer_q;
    assign bus.WriteAddressSelect = waddr_q;
    assign bus.writeIn            = wdata_q;
    assign bus.busy               = busy_q;
    assign bus.loadDone           = done_q;

endmodule

// File: tb/tb_nn_weight_loader.sv
// Scoreboard bench for nn_weight_loader with a 4/3-word, 8-bit configuration.
module tb_nn_weight_loader;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic       we;
        logic       be;
        logic       layer;
        logic [9:0] addr;
        logic [7:0] data;
        logic       done;
        logic       busy;
    } strobe_t;

    logic clk;
    logic rst_n;

    nn_weight_loader_if #(.DATA_W(DW)) bus ();

    nn_weight_loader #(
        .DATA_W          (DW),
        .L1_WEIGHT_COUNT (4),
        .L2_WEIGHT_COUNT (3)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      checks    = 0;
    int      errors    = 0;
    int      strobes   = 0;
    int      accepted  = 0;
    int      cyc       = 0;
    int      last_cyc  = -1;
    int      exp_gap   = 0;
    strobe_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-written expected strobe for beat k of a full load (L1: 4 W + bias, L2: 3 W + bias).
    function automatic strobe_t expected_beat(input int k, input logic [7:0] d);
        strobe_t s;
        case (k)
            0: s = '{we:1'b1, be:1'b0, layer:1'b0, addr:10'd0, data:d, done:1'b0, busy:1'b1};
            1: s = '{we:1'b1, be:1'b0, layer:1'b0, addr:10'd1, data:d, done:1'b0, busy:1'b1};
            2: s = '{we:1'b1, be:1'b0, layer:1'b0, addr:10'd2, data:d, done:1'b0, busy:1'b1};
            3: s = '{we:1'b1, be:1'b0, layer:1'b0, addr:10'd3, data:d, done:1'b0, busy:1'b1};
            4: s = '{we:1'b0, be:1'b1, layer:1'b0, addr:10'd0, data:d, done:1'b0, busy:1'b1};
            5: s = '{we:1'b1, be:1'b0, layer:1'b1, addr:10'd0, data:d, done:1'b0, busy:1'b1};
            6: s = '{we:1'b1, be:1'b0, layer:1'b1, addr:10'd1, data:d, done:1'b0, busy:1'b1};
            7: s = '{we:1'b1, be:1'b0, layer:1'b1, addr:10'd2, data:d, done:1'b0, busy:1'b1};
            default: s = '{we:1'b0, be:1'b1, layer:1'b1, addr:10'd0, data:d, done:1'b1, busy:1'b1};
        endcase
        return s;
    endfunction

    // Monitor: enable exclusivity every cycle, and pop/compare on every strobe.
    initial begin
        strobe_t e;
        strobe_t a;
        forever begin
            @(negedge clk);
            checks++;
            if (bus.weightWriteEnable && bus.biasWriteEnable) begin
                errors++;
                $display("FAIL enable_exclusive: both enables high at cycle %0d", cyc);
            end
            if (bus.weightWriteEnable || bus.biasWriteEnable) begin
                strobes++;
                a = '{we:bus.weightWriteEnable, be:bus.biasWriteEnable, layer:bus.LayerWriteSelect,
                      addr:bus.WriteAddressSelect, data:bus.writeIn, done:bus.loadDone, busy:bus.busy};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got %h, required no strobe", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL strobe: got we=%b be=%b L=%b a=%0d d=%h done=%b busy=%b required we=%b be=%b L=%b a=%0d d=%h done=%b busy=%b",
                                 a.we, a.be, a.layer, a.addr, a.data, a.done, a.busy,
                                 e.we, e.be, e.layer, e.addr, e.data, e.done, e.busy);
                    end
                end
                if (exp_gap != 0 && last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != exp_gap) begin
                        errors++;
                        $display("FAIL strobe_gap: got %0d cycles required %0d", cyc - last_cyc, exp_gap);
                    end
                end
                last_cyc = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({bus.dataReady, bus.weightWriteEnable, bus.biasWriteEnable, bus.LayerWriteSelect,
                         bus.WriteAddressSelect, bus.writeIn, bus.busy, bus.loadDone}), 32'd0);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        last_cyc = -1;
    endtask

    // Drives beats [0, n) of data base+k; optional valid toggling and a start pulse at one beat.
    task automatic send_beats(input int n, input logic [7:0] base, input bit toggle, input int start_at);
        int beat = 0;
        int iter = 0;
        logic v;
        logic acc;
        while (beat < n) begin
            if (iter > 200) begin
                errors++;
                checks++;
                $display("FAIL beat_timeout: got %0d beats required %0d", beat, n);
                break;
            end
            v = toggle ? ((iter % 2) == 0) : 1'b1;
            bus.dataValid = v;
            bus.dataIn    = base + 8'(beat);
            bus.start     = (beat == start_at) && v;
            @(negedge clk);
            acc = v && bus.dataReady;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (acc) begin
                exp_q.push_back(expected_beat(beat, base + 8'(beat)));
                accepted++;
                beat++;
            end
            iter++;
        end
        bus.dataValid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.dataValid = 1'b0;
        bus.dataIn    = '0;
        #12;
        check_all_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_outputs");

        // Full load, valid every cycle.
        exp_gap = 1;
        pulse_start();
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("ready_after_start", 32'(bus.dataReady), 32'd1);
        send_beats(9, 8'h10, 1'b0, -1);
        @(posedge clk);
        #1;
        check("done_held", 32'(bus.loadDone), 32'd1);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        check("ready_after_done", 32'(bus.dataReady), 32'd0);
        check("hold_addr", 32'(bus.WriteAddressSelect), 32'd0);
        check("hold_data", 32'(bus.writeIn), 32'h18);
        check("hold_layer", 32'(bus.LayerWriteSelect), 32'd1);

        // Restart from DONE, then load with dataValid toggling.
        exp_gap = 2;
        pulse_start();
        check("done_cleared_on_start", 32'(bus.loadDone), 32'd0);
        check("busy_on_restart", 32'(bus.busy), 32'd1);
        send_beats(9, 8'h20, 1'b1, -1);
        repeat (2) @(posedge clk);
        #1;
        check("done_after_toggle", 32'(bus.loadDone), 32'd1);

        // Start pulsed while loading L1 address 2 is ignored.
        exp_gap = 1;
        pulse_start();
        send_beats(9, 8'h40, 1'b0, 2);
        repeat (2) @(posedge clk);
        #1;
        check("done_after_ignored_start", 32'(bus.loadDone), 32'd1);

        // Reset mid layer-2 weights (next address 1), then a clean reload.
        pulse_start();
        send_beats(6, 8'h60, 1'b0, -1);
        repeat (3) @(posedge clk);
        #1;
        check("busy_mid_l2", 32'(bus.busy), 32'd1);
        check("ready_mid_l2", 32'(bus.dataReady), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        send_beats(9, 8'h80, 1'b0, -1);
        repeat (3) @(posedge clk);
        #1;
        check("done_after_reload", 32'(bus.loadDone), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("strobes_eq_beats", 32'(strobes), 32'(accepted));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
